tug_round_referee: RTL and testbench
====================================

Name: tug_round_referee

Overview:
- Sits directly downstream of the playfield light chain in the rhythm/tug-of-war game.
- Watches the two end lights and the conditioned player press pulses, and decides when a round is won.
- Keeps a per-player round score and holds the board frozen for a display interval.
- Drives the shared softReset that recentres every playfield light. Declares the match over at WIN_SCORE.

Parameters:
HOLD_CYCLES, 50000000, number of clk cycles the winner indication is held before the board is recentred (legal range 1 to 2^26-1)
WIN_SCORE, 3, rounds needed to win the match (legal range 1 to 7)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset; one clock domain, no other reset
L  input  1  left player press pulse, one cycle per press, already synchronised
R  input  1  right player press pulse, one cycle per press, already synchronised
leftEnd  input  1  lightOn of the leftmost playfield light
rightEnd  input  1  lightOn of the rightmost playfield light
softReset  output  1  one-cycle pulse that recentres the playfield lights
winner  output  2  00 none, 01 left won the current round, 10 right won; 11 is never driven
leftScore  output  3  left player rounds won, unsigned
rightScore  output  3  right player rounds won, unsigned
matchOver  output  1  high once either score reaches WIN_SCORE

Behaviour:
- Reset values: state PLAY, hold counter 0, softReset 0, winner 00, leftScore 0, rightScore 0, matchOver 0.
- Reset takes priority over every other event. This includes reset mid-HOLD, mid-CLEAR and in OVER.
- FSM states: PLAY, HOLD, CLEAR, OVER. All state and outputs are registered. Outputs are Moore-style from registers.
- Left point condition, PLAY only: leftEnd & L & ~R.
- Right point condition, PLAY only: rightEnd & R & ~L.
- L & R in the same cycle never scores, whatever the end lights show.
- leftEnd and rightEnd both high is illegal upstream. The L/R qualification still yields at most one point per cycle.
- PLAY, point on edge k. On edge k the block:
  - increments the scoring player's score by 1;
  - sets winner to 01 or 10;
  - loads the hold counter with HOLD_CYCLES-1;
  - goes to HOLD.
- The new score and winner are visible the cycle after the qualifying input cycle.
- PLAY, no point: stay in PLAY. Outputs are unchanged.
- HOLD: L, R, leftEnd and rightEnd are ignored.
  - Counter nonzero: decrement by 1, stay in HOLD.
  - Counter zero: if the winning player's score equals WIN_SCORE, go to OVER; otherwise go to CLEAR.
  - HOLD therefore lasts exactly HOLD_CYCLES cycles.
- CLEAR: lasts exactly one cycle.
  - softReset = 1 in this cycle only.
  - winner returns to 00 on the exit edge.
  - Next state is PLAY.
- OVER: absorbing until reset.
  - matchOver = 1, set on the edge entering OVER.
  - winner stays at the final winner. Scores are frozen.
  - softReset stays 0, so the board stays frozen showing the final position.
- softReset is high exactly when state == CLEAR. It is never high for two consecutive cycles.
- Score arithmetic: 3-bit unsigned. A score never exceeds WIN_SCORE, because entering OVER stops all counting. No wrap-around is possible within the legal parameter range.
- Hold counter width: 26 bits. Loading HOLD_CYCLES-1 = 0 gives a one-cycle HOLD.
- Full round latency: qualifying press on cycle k, HOLD on cycles k+1 to k+HOLD_CYCLES, softReset on cycle k+HOLD_CYCLES+1, PLAY from cycle k+HOLD_CYCLES+2.

Test Plan:
(Bench parameters: HOLD_CYCLES=4, WIN_SCORE=3.)
- Reset, then leftEnd=1, L=1, R=0 for one cycle -> next cycle winner=01, leftScore=1; softReset=1 for exactly one cycle, 5 cycles after the press; winner=00 afterwards.
- leftEnd=1 with L=1, R=1 together; then rightEnd=0 with R=1 -> no score change, winner stays 00, softReset never asserts.
- Right wins three rounds in sequence (rightEnd=1, R pulse, wait for CLEAR each time) -> rightScore 1,2,3; after the third HOLD, matchOver=1, winner=10, no softReset pulse; further presses leave all outputs unchanged.
- During HOLD, toggle L, R, leftEnd and rightEnd every cycle -> scores and counter unaffected; CLEAR still arrives on schedule.
- Assert reset in the second HOLD cycle after a left point -> next cycle state PLAY, leftScore=0, winner=00, softReset=0; a new left point afterwards yields leftScore=1.
- Alternate left and right points until left reaches 3 -> leftScore=3, rightScore=2, matchOver=1, winner=01.

Source files
------------

// File: rtl/tug_round_referee.sv
`default_nettype none
// ============================================================================
//  Module   : tug_round_referee
//  Brief    : Round/match referee for the tug-of-war playfield. Detects a
//             qualified press at an end light, scores the round, freezes the
//             board for HOLD_CYCLES, then pulses softReset to recentre the
//             lights, or latches matchOver once a player reaches WIN_SCORE.
//  Revision : 1.0  initial release
// ============================================================================
module tug_round_referee #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int WIN_SCORE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       leftEnd,
    input  logic       rightEnd,
    output logic       softReset,
    output logic [1:0] winner,
    output logic [2:0] leftScore,
    output logic [2:0] rightScore,
    output logic       matchOver
);

    localparam logic [25:0] c_hold_load = 26'(HOLD_CYCLES - 1);
    localparam logic [2:0]  c_win_score = 3'(WIN_SCORE);
    localparam logic [1:0]  c_win_none  = 2'b00;
    localparam logic [1:0]  c_win_left  = 2'b01;
    localparam logic [1:0]  c_win_right = 2'b10;

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_HOLD  = 2'd1,
        S_CLEAR = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic [25:0] r_hold_cnt,    w_hold_cnt_nxt;
    logic [2:0]  r_left_score,  w_left_score_nxt;
    logic [2:0]  r_right_score, w_right_score_nxt;
    logic [1:0]  r_winner,      w_winner_nxt;
    logic        r_soft_reset,  w_soft_reset_nxt;
    logic        r_match_over,  w_match_over_nxt;

    // Simultaneous presses cancel, so at most one point can qualify per cycle
    // even if both end lights were (illegally) lit.
    logic w_left_point;
    logic w_right_point;
    logic w_round_final;

    assign w_left_point  = leftEnd  & L & ~R;
    assign w_right_point = rightEnd & R & ~L;

    // The round that just finished ends the match if its winner hit WIN_SCORE.
    assign w_round_final = (r_winner == c_win_left) ? (r_left_score  == c_win_score)
                                                    : (r_right_score == c_win_score);

    // State and output registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_PLAY;
            r_hold_cnt    <= '0;
            r_left_score  <= '0;
            r_right_score <= '0;
            r_winner      <= c_win_none;
            r_soft_reset  <= 1'b0;
            r_match_over  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_left_score  <= w_left_score_nxt;
            r_right_score <= w_right_score_nxt;
            r_winner      <= w_winner_nxt;
            r_soft_reset  <= w_soft_reset_nxt;
            r_match_over  <= w_match_over_nxt;
        end
    end

    // Next-state and next-output logic; softReset is registered so it is high
    // exactly while the state register holds CLEAR.
    always_comb begin
        w_state_nxt       = r_state;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_left_score_nxt  = r_left_score;
        w_right_score_nxt = r_right_score;
        w_winner_nxt      = r_winner;
        w_soft_reset_nxt  = 1'b0;
        w_match_over_nxt  = r_match_over;

        unique case (r_state)
            S_PLAY: begin
                if (w_left_point) begin
                    w_left_score_nxt = r_left_score + 3'd1;
                    w_winner_nxt     = c_win_left;
                    w_hold_cnt_nxt   = c_hold_load;
                    w_state_nxt      = S_HOLD;
                end else if (w_right_point) begin
                    w_right_score_nxt = r_right_score + 3'd1;
                    w_winner_nxt      = c_win_right;
                    w_hold_cnt_nxt    = c_hold_load;
                    w_state_nxt       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt != 26'd0) begin
                    w_hold_cnt_nxt = r_hold_cnt - 26'd1;
                end else if (w_round_final) begin
                    w_match_over_nxt = 1'b1;
                    w_state_nxt      = S_OVER;
                end else begin
                    w_soft_reset_nxt = 1'b1;
                    w_state_nxt      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_winner_nxt = c_win_none;
                w_state_nxt  = S_PLAY;
            end
            S_OVER: begin
                w_state_nxt = S_OVER;
            end
            default: begin
                w_state_nxt = S_PLAY;
            end
        endcase
    end

    assign softReset  = r_soft_reset;
    assign winner     = r_winner;
    assign leftScore  = r_left_score;
    assign rightScore = r_right_score;
    assign matchOver  = r_match_over;

endmodule
`default_nettype wire

// File: tb/tb_tug_round_referee.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tug_round_referee
//  Brief    : Self-checking bench for tug_round_referee: constant vector
//             table, hand-written round/match sequences and randomized play
//             against a timeline-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tug_round_referee;

    localparam int c_HOLD = 4;
    localparam int c_WIN  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       L = 1'b0;
    logic       R = 1'b0;
    logic       leftEnd = 1'b0;
    logic       rightEnd = 1'b0;
    logic       softReset;
    logic [1:0] winner;
    logic [2:0] leftScore;
    logic [2:0] rightScore;
    logic       matchOver;

    tug_round_referee #(
        .HOLD_CYCLES (c_HOLD),
        .WIN_SCORE   (c_WIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .L          (L),
        .R          (R),
        .leftEnd    (leftEnd),
        .rightEnd   (rightEnd),
        .softReset  (softReset),
        .winner     (winner),
        .leftScore  (leftScore),
        .rightScore (rightScore),
        .matchOver  (matchOver)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a round is described by the cycle k of its winning
    // press. Cycles k+1..k+H show the winner, cycle k+H+1 is the recentre
    // pulse (or the start of the frozen final board), play resumes at k+H+2.
    int         cyc = 0;
    int         m_k;
    int         m_ls;
    int         m_rs;
    logic [1:0] m_w;
    bit         m_fin;
    logic [9:0] m_exp;

    typedef struct packed {
        logic       l;
        logic       r;
        logic       le;
        logic       re;
        logic       sr;
        logic [1:0] w;
        logic [2:0] ls;
        logic [2:0] rs;
        logic       mo;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [9:0] pack_out(logic sr, logic [1:0] w, logic [2:0] ls,
                                            logic [2:0] rs, logic mo);
        return {sr, w, ls, rs, mo};
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {softReset, winner, leftScore, rightScore, matchOver};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got sr=%b w=%b ls=%0d rs=%0d mo=%b want sr=%b w=%b ls=%0d rs=%0d mo=%b",
                     name, cyc, act[9], act[8:7], act[6:4], act[3:1], act[0],
                     exp[9], exp[8:7], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_k   = -1000;
        m_ls  = 0;
        m_rs  = 0;
        m_w   = 2'b00;
        m_fin = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic r, input logic le, input logic re);
        int  n;
        bit  sr;
        bit  mo;
        logic [1:0] w;
        if (!m_fin && cyc >= m_k + c_HOLD + 2) begin
            if (le && l && !r) begin
                m_ls++; m_w = 2'b01; m_k = cyc; m_fin = (m_ls == c_WIN);
            end else if (re && r && !l) begin
                m_rs++; m_w = 2'b10; m_k = cyc; m_fin = (m_rs == c_WIN);
            end
        end
        n  = cyc + 1;
        w  = (m_fin || (n >= m_k + 1 && n <= m_k + c_HOLD + 1)) ? m_w : 2'b00;
        sr = !m_fin && (n == m_k + c_HOLD + 1);
        mo = m_fin && (n >= m_k + c_HOLD + 1);
        m_exp = pack_out(sr, w, 3'(m_ls), 3'(m_rs), mo);
    endtask

    // One clock: drive inputs, let the edge happen, compare with the model.
    task automatic step(input logic l, input logic r, input logic le, input logic re);
        L = l; R = r; leftEnd = le; rightEnd = re;
        @(posedge clk);
        #1;
        model_step(l, r, le, re);
        cyc++;
        check("model", m_exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        model_reset();
        check("reset", pack_out(1'b0, 2'b00, 3'd0, 3'd0, 1'b0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // Left round then non-scoring press patterns; {l,r,le,re, sr,w,ls,rs,mo}.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'd1, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 3'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 3'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 3'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'd1, 3'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1, 3'd0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd1, 3'd0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1, 3'd0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'd1, 3'd0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1, 3'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].l, tbl[i].r, tbl[i].le, tbl[i].re);
            check($sformatf("table[%0d]", i),
                  pack_out(tbl[i].sr, tbl[i].w, tbl[i].ls, tbl[i].rs, tbl[i].mo));
        end

        // Right wins the match; the final round freezes with no recentre.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            check("right_round_score", pack_out(1'b0, 2'b10, 3'd0, 3'(i + 1), 1'b0));
            idle(i < 2 ? 5 : 4);
        end
        check("right_match_over", pack_out(1'b0, 2'b10, 3'd0, 3'd3, 1'b1));
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("over_frozen", pack_out(1'b0, 2'b10, 3'd0, 3'd3, 1'b1));

        // Inputs toggling throughout HOLD and CLEAR are ignored.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("hold_toggle_clear", pack_out(1'b1, 2'b10, 3'd0, 3'd1, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("clear_ignores_press", pack_out(1'b0, 2'b00, 3'd0, 3'd1, 1'b0));

        // Reset in the second HOLD cycle wipes the round.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("after_reset_point", pack_out(1'b0, 2'b01, 3'd1, 3'd0, 1'b0));

        // Alternating points, left reaches the match score first.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, 1'b1, 1'b0);
            else            step(1'b0, 1'b1, 1'b0, 1'b1);
            idle(i < 4 ? 5 : 4);
        end
        check("left_match_over", pack_out(1'b0, 2'b01, 3'd3, 3'd2, 1'b1));

        // Randomized play against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int e;
            logic l, r;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                l = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 2) == 0);
                e = int'($urandom_range(0, 2));
                step(l, r, e == 1, e == 2);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
